seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream display stage of the digital clock. Takes binary hour/min/sec from the
//  chained modulo counters and drives a 6-digit multiplexed common-anode 7-seg display.
//  Does binary->BCD split, time-multiplexed digit scan and per-frame snapshot (no tearing).
// PARAMETERS
//  SCAN_DIV  50000  clk cycles per digit slot (>=1); frame = 6*SCAN_DIV cycles
//  DIV_W     16     prescaler width; must satisfy 2**DIV_W >= SCAN_DIV
//  BLANK_LZ  1      1: blank hour-tens digit when it is 0; 0: show '0'
//  HOUR_MAX  23     largest legal hour value (11 for a 12h variant)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-low reset
//  hour       in   5  binary hour from hour counter
//  min        in   6  binary minute from minute counter
//  sec        in   6  binary second from second counter
//  digit_an   out  6  digit enables, active-low one-hot; bit0=sec ones .. bit5=hour tens
//  seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//  frame_start out 1  1-cycle pulse: new snapshot loaded, scan at digit 0
// BEHAVIOUR
//  Reset (reset=0, async, immediate): div_cnt=0, idx=0, snapshot=0, digit_an=6'h3F,
//   seg=7'h7F, frame_start=0. Asserting mid-scan forces these at once.
//  Prescaler: div_cnt counts 0..SCAN_DIV-1, wraps to 0; tick=1 in the cycle div_cnt==SCAN_DIV-1.
//   SCAN_DIV=1 -> tick every cycle.
//  Digit index: idx 0..5 advances on edge ending a tick cycle; 5 wraps to 0.
//  Snapshot: on the edge where idx wraps 5->0, hour/min/sec latched into snap regs;
//   frame_start=1 in the following cycle only (same cycle idx reads 0).
//   Input changes between wraps have no effect on the display.
//  Digit map: idx0 sec%10, 1 sec/10, 2 min%10, 3 min/10, 4 hour%10, 5 hour/10.
//   BCD split is pure combinational on snap values; no multi-cycle divider.
//  Range check: sec or min >59, or hour >HOUR_MAX -> both digits of that field
//   show dash 7'b0111111 (only g lit). Other fields unaffected.
//  Leading zero: BLANK_LZ=1 and hour/10==0 (legal hour) -> idx5 seg=7'h7F,
//   digit_an still asserted.
//  Output timing: digit_an and seg registered from (idx, snap); they change one clk
//   after idx changes, always together (no cycle with new anode + old segments).
//  digit_an = ~(6'b1 << idx) registered; exactly one bit low at all times after the first
//   post-reset edge.
//  Seg codes (g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
//  Post-reset: first edge loads idx0, snap=0 -> digit_an=3E, seg=40; first frame shows
//   00:00:00 (hour tens blanked if BLANK_LZ), live values from the first frame_start.
// TESTING (bench SCAN_DIV=4 unless noted)
//  1 Reset: drop reset mid-slot at idx3 -> digit_an=3F, seg=7F same cycle, div_cnt/idx=0 after.
//  2 hour=12,min=34,sec=56 after 1st frame_start -> (an,seg) per slot 4 cycles each:
//    3E/0000010, 3D/0010010, 3B/0011001, 37/0110000, 2F/0100100, 1F/1111001.
//  3 Tearing: change sec 56->57 at idx2 -> idx0 still shows 6 until next frame_start, then 7.
//  4 hour=5: BLANK_LZ=1 -> at idx5 an=1F, seg=7F; BLANK_LZ=0 -> seg=1000000.
//  5 min=60, hour=24 -> idx2..5 seg=0111111; sec digits normal.
//  6 Periods: frame_start every 24 cycles exactly; SCAN_DIV=1 -> every 6 cycles, idx steps each clk.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Display stage of the digital clock. Snapshots binary hour/min/sec once per frame,
//   splits each field into BCD digits and scans a 6-digit common-anode 7-seg display.
//
// Parameters
//   SCAN_DIV  clk cycles per digit slot (>= 1); one frame is 6*SCAN_DIV cycles
//   DIV_W     prescaler width, 2**DIV_W >= SCAN_DIV
//   BLANK_LZ  1: blank the hour-tens digit when it is 0
//   HOUR_MAX  largest legal hour value
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   hour         binary hour (5 bits)
//   min          binary minute (6 bits)
//   sec          binary second (6 bits)
//   digit_an     digit enables, active-low one-hot; bit0 = sec ones .. bit5 = hour tens
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   frame_start  1-cycle pulse: new snapshot loaded, scan at digit 0

module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIV_W    = 16,
  parameter bit          BLANK_LZ = 1'b1,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [5:0] digit_an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(SCAN_DIV - 1);
  localparam logic [4:0]       HourMax = 5'(HOUR_MAX);
  localparam logic [2:0]       IdxLast = 3'd5;
  localparam logic [6:0]       SegDash  = 7'b0111111;
  localparam logic [6:0]       SegBlank = 7'h7F;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [4:0]       snap_hour_q, snap_hour_d;
  logic [5:0]       snap_min_q, snap_min_d;
  logic [5:0]       snap_sec_q, snap_sec_d;
  logic [5:0]       digit_an_q, digit_an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_start_q, frame_start_d;

  logic tick;
  logic wrap;

  function automatic logic [3:0] tens_of(logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] ones_of(logic [5:0] v);
    logic [5:0] o;
    o = v % 6'd10;
    return o[3:0];
  endfunction

  function automatic logic [6:0] seg_enc(logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      snap_hour_q   <= '0;
      snap_min_q    <= '0;
      snap_sec_q    <= '0;
      digit_an_q    <= 6'h3F;
      seg_q         <= SegBlank;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      snap_hour_q   <= snap_hour_d;
      snap_min_q    <= snap_min_d;
      snap_sec_q    <= snap_sec_d;
      digit_an_q    <= digit_an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Prescaler, scan index and per-frame snapshot
  always_comb begin
    tick        = (div_cnt_q == DivLast);
    wrap        = tick && (idx_q == IdxLast);
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    idx_d       = idx_q;
    snap_hour_d = snap_hour_q;
    snap_min_d  = snap_min_q;
    snap_sec_d  = snap_sec_q;
    if (tick) begin
      idx_d = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
    end
    // Latching only at the frame wrap keeps a whole frame coherent (no tearing).
    if (wrap) begin
      snap_hour_d = hour;
      snap_min_d  = min;
      snap_sec_d  = sec;
    end
    frame_start_d = wrap;
  end

  // Digit select and decode; anode and segments are registered together from (idx, snap)
  always_comb begin
    logic [5:0] field_val;
    logic       field_bad;
    logic [3:0] digit;
    logic       blank;

    field_val = 6'd0;
    field_bad = 1'b0;
    case (idx_q)
      3'd0, 3'd1: begin
        field_val = snap_sec_q;
        field_bad = (snap_sec_q > 6'd59);
      end
      3'd2, 3'd3: begin
        field_val = snap_min_q;
        field_bad = (snap_min_q > 6'd59);
      end
      3'd4, 3'd5: begin
        field_val = {1'b0, snap_hour_q};
        field_bad = (snap_hour_q > HourMax);
      end
      default: begin
        field_val = 6'd0;
        field_bad = 1'b0;
      end
    endcase

    // Odd slots carry the tens digit of their field.
    digit = idx_q[0] ? tens_of(field_val) : ones_of(field_val);
    blank = BLANK_LZ && (idx_q == IdxLast) && !field_bad && (digit == 4'd0);

    if (field_bad) begin
      seg_d = SegDash;
    end else if (blank) begin
      seg_d = SegBlank;
    end else begin
      seg_d = seg_enc(digit);
    end
    digit_an_d = ~(6'b000001 << idx_q);
  end

  assign digit_an    = digit_an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic       clk;
  logic       reset;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [5:0] digit_an, an_nb, an_fast;
  logic [6:0] seg, seg_nb, seg_fast;
  logic       frame_start, fs_nb, fs_fast;

  int n_pass  = 0;
  int n_total = 0;

  logic [12:0] q[$];
  logic [12:0] q_nb[$];

  seg7_scan_driver #(.SCAN_DIV(4), .DIV_W(3), .BLANK_LZ(1'b1), .HOUR_MAX(23)) dut (
    .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec),
    .digit_an(digit_an), .seg(seg), .frame_start(frame_start)
  );

  seg7_scan_driver #(.SCAN_DIV(4), .DIV_W(3), .BLANK_LZ(1'b0), .HOUR_MAX(23)) dut_nb (
    .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec),
    .digit_an(an_nb), .seg(seg_nb), .frame_start(fs_nb)
  );

  seg7_scan_driver #(.SCAN_DIV(1), .DIV_W(1), .BLANK_LZ(1'b1), .HOUR_MAX(23)) dut_fast (
    .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec),
    .digit_an(an_fast), .seg(seg_fast), .frame_start(fs_fast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] code_of(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model for one slot: {digit_an, seg}
  function automatic logic [12:0] exp_slot(int j, int h, int m, int s, bit blz);
    int v;
    bit bad;
    int d;
    logic [6:0] sg;
    logic [5:0] an;
    an  = 6'h3F ^ (6'b000001 << j);
    v   = (j < 2) ? s : (j < 4) ? m : h;
    bad = (j < 2) ? (s > 59) : (j < 4) ? (m > 59) : (h > 23);
    d   = (j % 2 == 0) ? v % 10 : v / 10;
    if (bad) sg = 7'b0111111;
    else if (j == 5 && blz && d == 0) sg = 7'h7F;
    else sg = code_of(d);
    return {an, sg};
  endfunction

  task automatic push_frame(int h, int m, int s);
    for (int j = 0; j < 6; j++) begin
      q.push_back(exp_slot(j, h, m, s, 1'b1));
      q_nb.push_back(exp_slot(j, h, m, s, 1'b0));
    end
  endtask

  task automatic set_inputs(int h, int m, int s);
    hour = 5'(h);
    min  = 6'(m);
    sec  = 6'(s);
  endtask

  // Advance until frame_start is seen on the SCAN_DIV=4 instances.
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 40);
    n_total++;
    if (!frame_start) $display("FAIL wait_frame: frame_start=%b after %0d cycles, required 1", frame_start, n);
    else n_pass++;
  endtask

  // Pops one frame of expectations; caller is at the negedge where frame_start is high.
  task automatic drain_frame(int mod_slot, logic [5:0] new_sec);
    logic [12:0] e, e_nb;
    for (int j = 0; j < 6; j++) begin
      if (j == mod_slot) sec = new_sec;
      if (q.size() == 0 || q_nb.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_empty: slot %0d has no expected value, required one", j);
        continue;
      end
      e    = q.pop_front();
      e_nb = q_nb.pop_front();
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        n_total++;
        if ({digit_an, seg} !== e)
          $display("FAIL slot%0d_cyc%0d: an=%h seg=%b, required an=%h seg=%b",
                   j, c, digit_an, seg, e[12:7], e[6:0]);
        else n_pass++;
        n_total++;
        if ({an_nb, seg_nb} !== e_nb)
          $display("FAIL nb_slot%0d_cyc%0d: an=%h seg=%b, required an=%h seg=%b",
                   j, c, an_nb, seg_nb, e_nb[12:7], e_nb[6:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    set_inputs(0, 0, 0);
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (digit_an !== 6'h3F) $display("FAIL reset_an: %h, required 3f", digit_an); else n_pass++;
    n_total++;
    if (seg !== 7'h7F) $display("FAIL reset_seg: %h, required 7f", seg); else n_pass++;
    n_total++;
    if (frame_start !== 1'b0) $display("FAIL reset_fs: %b, required 0", frame_start); else n_pass++;
    // First frame after reset shows the zeroed snapshot.
    push_frame(0, 0, 0);
    reset = 1'b1;
    drain_frame(-1, 6'd0);
    n_total++;
    if (frame_start !== 1'b1) $display("FAIL first_frame_start: %b, required 1", frame_start);
    else n_pass++;
  endtask

  task automatic test_display();
    set_inputs(12, 34, 56);
    push_frame(12, 34, 56);
    wait_frame();
    drain_frame(-1, 6'd0);
  endtask

  task automatic test_blank();
    set_inputs(5, 7, 9);
    push_frame(5, 7, 9);
    wait_frame();
    drain_frame(-1, 6'd0);
  endtask

  task automatic test_range();
    set_inputs(24, 60, 7);
    push_frame(24, 60, 7);
    wait_frame();
    drain_frame(-1, 6'd0);
    set_inputs(23, 59, 61);
    push_frame(23, 59, 61);
    wait_frame();
    drain_frame(-1, 6'd0);
  endtask

  task automatic test_tearing();
    set_inputs(12, 34, 56);
    push_frame(12, 34, 56);
    wait_frame();
    drain_frame(2, 6'd57);
    push_frame(12, 34, 57);
    n_total++;
    if (frame_start !== 1'b1) $display("FAIL tear_fs: %b, required 1", frame_start); else n_pass++;
    drain_frame(-1, 6'd0);
  endtask

  task automatic test_period();
    int n;
    wait_frame();
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!frame_start && n < 60);
      n_total++;
      if (n !== 24) $display("FAIL period4_%0d: %0d cycles, required 24", k, n); else n_pass++;
    end
    n = 0;
    while (!fs_fast && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (fs_fast !== 1'b1) $display("FAIL fast_fs_seen: %b, required 1", fs_fast); else n_pass++;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      n_total++;
      if (an_fast !== (6'h3F ^ (6'b000001 << j)))
        $display("FAIL fast_an%0d: %h, required %h", j, an_fast, 6'h3F ^ (6'b000001 << j));
      else n_pass++;
      n_total++;
      if (fs_fast !== (j == 5))
        $display("FAIL fast_fs%0d: %b, required %b", j, fs_fast, (j == 5));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    wait_frame();
    repeat (14) @(negedge clk);
    n_total++;
    if (digit_an !== 6'h37) $display("FAIL mid_pre_an: %h, required 37", digit_an); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (digit_an !== 6'h3F) $display("FAIL mid_an: %h, required 3f", digit_an); else n_pass++;
    n_total++;
    if (seg !== 7'h7F) $display("FAIL mid_seg: %h, required 7f", seg); else n_pass++;
    n_total++;
    if (dut.div_cnt_q !== 3'd0) $display("FAIL mid_div: %0d, required 0", dut.div_cnt_q);
    else n_pass++;
    n_total++;
    if (dut.idx_q !== 3'd0) $display("FAIL mid_idx: %0d, required 0", dut.idx_q); else n_pass++;
    @(negedge clk);
    n_total++;
    if ({digit_an, seg} !== {6'h3F, 7'h7F})
      $display("FAIL mid_hold: an=%h seg=%h, required 3f/7f", digit_an, seg);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({digit_an, seg} !== {6'h3E, 7'h40})
      $display("FAIL mid_first: an=%h seg=%h, required 3e/40", digit_an, seg);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_display();
    test_blank();
    test_range();
    test_tearing();
    test_period();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
